// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register file write port, clears regs 1..NREG-1
// and round-robins writes between requester A (writeback) and B (loader).
// Ports: CLK/nRST, clr_start/clr_busy, a_*/b_* req+sel+dat with gnt,
//        rf_WEN/rf_wsel/rf_wdat (registered), conflict_cnt (saturating).
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NREG         = 32,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_wsel,
  input  logic [DATA_W-1:0] a_wdat,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_wsel,
  input  logic [DATA_W-1:0] b_wdat,
  output logic              b_gnt,
  output logic              rf_WEN,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic [DATA_W-1:0] rf_wdat,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {CLEAR, ARB} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  // prio: 0 = A holds priority, 1 = B holds priority
  logic              prio, prio_nxt;
  logic              a_win, b_win;
  logic              wen_nxt;
  logic [ADDR_W-1:0] wsel_nxt;
  logic [DATA_W-1:0] wdat_nxt;
  logic              conf_inc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      if (CLR_ON_RESET) state <= CLEAR;
      else              state <= ARB;
      cnt          <= ONE;
      prio         <= 1'b0;
      rf_WEN       <= 1'b0;
      rf_wsel      <= '0;
      rf_wdat      <= '0;
      conflict_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      prio    <= prio_nxt;
      rf_WEN  <= wen_nxt;
      rf_wsel <= wsel_nxt;
      rf_wdat <= wdat_nxt;
      if (conf_inc && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prio_nxt  = prio;
    a_win     = 1'b0;
    b_win     = 1'b0;
    wen_nxt   = 1'b0;
    wsel_nxt  = rf_wsel;
    wdat_nxt  = rf_wdat;
    conf_inc  = 1'b0;
    unique case (state)
      CLEAR: begin
        wen_nxt  = 1'b1;
        wsel_nxt = cnt;
        wdat_nxt = '0;
        if (cnt == LAST) begin
          state_nxt = ARB;
          cnt_nxt   = ONE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      ARB: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else begin
          a_win    = a_req & (~b_req | ~prio);
          b_win    = b_req & (~a_req | prio);
          conf_inc = a_req & b_req;
          if (a_win) begin
            wen_nxt  = 1'b1;
            wsel_nxt = a_wsel;
            wdat_nxt = a_wdat;
            prio_nxt = 1'b1;
          end
          if (b_win) begin
            wen_nxt  = 1'b1;
            wsel_nxt = b_wsel;
            wdat_nxt = b_wdat;
            prio_nxt = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // grants are combinational; hold them low while reset is asserted
  assign a_gnt    = a_win & nRST;
  assign b_gnt    = b_win & nRST;
  assign clr_busy = (state == CLEAR);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed bench with a write scoreboard for
// rf_write_arbiter (DATA_W=32, ADDR_W=5, NREG=32, CLR_ON_RESET=1).
module tb_rf_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = AW + DW;

  logic          CLK;
  logic          nRST;
  logic          clr_start;
  logic          clr_busy;
  logic          a_req;
  logic [AW-1:0] a_wsel;
  logic [DW-1:0] a_wdat;
  logic          a_gnt;
  logic          b_req;
  logic [AW-1:0] b_wsel;
  logic [DW-1:0] b_wdat;
  logic          b_gnt;
  logic          rf_WEN;
  logic [AW-1:0] rf_wsel;
  logic [DW-1:0] rf_wdat;
  logic [15:0]   conflict_cnt;

  int vectors = 0;
  int errs    = 0;

  logic [EW-1:0] sb[$];

  rf_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NREG(32), .CLR_ON_RESET(1'b1)
  ) dut (
    .CLK(CLK), .nRST(nRST), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_req(a_req), .a_wsel(a_wsel), .a_wdat(a_wdat), .a_gnt(a_gnt),
    .b_req(b_req), .b_wsel(b_wsel), .b_wdat(b_wdat), .b_gnt(b_gnt),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .conflict_cnt(conflict_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every registered write must match the oldest expectation
  always @(negedge CLK) begin
    if (nRST === 1'b1 && rf_WEN === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'({rf_wsel, rf_wdat}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [EW-1:0] e;
        e = sb.pop_front();
        chk("sb_write", 64'({rf_wsel, rf_wdat}), 64'(e));
      end
    end
  end

  task automatic push_clear(input int last);
    for (int i = 1; i <= last; i++) sb.push_back({AW'(i), DW'(0)});
  endtask

  task automatic run_clear();
    for (int i = 1; i <= 31; i++) begin
      @(posedge CLK); #1;
      chk("clr_wen", 64'(rf_WEN), 64'd1);
      chk("clr_wsel", 64'(rf_wsel), 64'(i));
      chk("clr_busy", 64'(clr_busy), 64'(i < 31));
    end
  endtask

  int  na, nb, econf;
  bit  mprio;
  bit  ea, eb;

  initial begin
    nRST = 1'b0; clr_start = 1'b0;
    a_req = 1'b0; a_wsel = '0; a_wdat = '0;
    b_req = 1'b0; b_wsel = '0; b_wdat = '0;
    mprio = 1'b0; econf = 0;
    #2;
    chk("rst_wen", 64'(rf_WEN), 64'd0);
    chk("rst_wsel", 64'(rf_wsel), 64'd0);
    chk("rst_wdat", 64'(rf_wdat), 64'd0);
    chk("rst_agnt", 64'(a_gnt), 64'd0);
    chk("rst_bgnt", 64'(b_gnt), 64'd0);
    chk("rst_conf", 64'(conflict_cnt), 64'd0);
    chk("rst_busy", 64'(clr_busy), 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    push_clear(31);
    nRST = 1'b1;
    run_clear();

    // single A write
    a_req = 1'b1; a_wsel = 5'd5; a_wdat = 32'hDEADBEEF;
    #1;
    chk("a_gnt", 64'(a_gnt), 64'd1);
    chk("a_bgnt0", 64'(b_gnt), 64'd0);
    sb.push_back({5'd5, 32'hDEADBEEF});
    mprio = 1'b1;
    @(posedge CLK); #1;
    a_req = 1'b0;
    chk("a_wen", 64'(rf_WEN), 64'd1);
    chk("a_wsel", 64'(rf_wsel), 64'd5);
    chk("a_wdat", 64'(rf_wdat), 64'hDEADBEEF);

    // B write to register 0 is passed through
    b_req = 1'b1; b_wsel = 5'd0; b_wdat = 32'd7;
    #1;
    chk("b0_gnt", 64'(b_gnt), 64'd1);
    chk("b0_agnt", 64'(a_gnt), 64'd0);
    sb.push_back({5'd0, 32'd7});
    mprio = 1'b0;
    @(posedge CLK); #1;
    b_req = 1'b0;
    chk("b0_wen", 64'(rf_WEN), 64'd1);
    chk("b0_wsel", 64'(rf_wsel), 64'd0);

    // both requesting; each drops after its second grant
    na = 0; nb = 0;
    for (int c = 0; c < 8 && (na < 2 || nb < 2); c++) begin
      a_req = (na < 2); a_wsel = 5'd1; a_wdat = 32'h100 + 32'(na);
      b_req = (nb < 2); b_wsel = 5'd2; b_wdat = 32'h200 + 32'(nb);
      #1;
      ea = a_req && (!b_req || !mprio);
      eb = b_req && (!a_req || mprio);
      chk("rr_agnt", 64'(a_gnt), 64'(ea));
      chk("rr_bgnt", 64'(b_gnt), 64'(eb));
      if (a_req && b_req) econf++;
      if (ea) begin
        sb.push_back({a_wsel, a_wdat}); na++; mprio = 1'b1;
      end
      if (eb) begin
        sb.push_back({b_wsel, b_wdat}); nb++; mprio = 1'b0;
      end
      @(posedge CLK); #1;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("rr_conf", 64'(conflict_cnt), 64'(econf));

    // clear request while A waits: A is held off, then granted
    a_req = 1'b1; a_wsel = 5'd9; a_wdat = 32'hCAFE;
    clr_start = 1'b1;
    #1;
    chk("clr_agnt0", 64'(a_gnt), 64'd0);
    @(posedge CLK); #1;
    clr_start = 1'b0;
    chk("clr_wen0", 64'(rf_WEN), 64'd0);
    push_clear(31);
    for (int i = 1; i <= 31; i++) begin
      chk("hold_busy", 64'(clr_busy), 64'd1);
      chk("hold_agnt", 64'(a_gnt), 64'd0);
      @(posedge CLK); #1;
    end
    chk("after_busy", 64'(clr_busy), 64'd0);
    chk("after_agnt", 64'(a_gnt), 64'd1);
    sb.push_back({5'd9, 32'hCAFE});
    mprio = 1'b1;
    @(posedge CLK); #1;
    a_req = 1'b0;
    chk("hold_conf", 64'(conflict_cnt), 64'(econf));

    // reset in the middle of a clear
    clr_start = 1'b1;
    push_clear(8);
    @(posedge CLK); #1;
    clr_start = 1'b0;
    repeat (9) begin
      @(posedge CLK); #1;
    end
    chk("mid_wsel9", 64'(rf_wsel), 64'd9);
    nRST = 1'b0;
    #1;
    chk("mid_wen", 64'(rf_WEN), 64'd0);
    chk("mid_wsel", 64'(rf_wsel), 64'd0);
    chk("mid_conf", 64'(conflict_cnt), 64'd0);
    chk("mid_busy", 64'(clr_busy), 64'd1);
    chk("mid_sb", 64'(sb.size()), 64'd0);
    @(posedge CLK); #1;
    push_clear(31);
    nRST = 1'b1;
    run_clear();
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("idle_wen", 64'(rf_WEN), 64'd0);
    chk("end_sb", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
